// File: rtl/corner_packer_if.sv
// Pixel-stream and coordinate-output bundle for corner_packer.
// The design side uses the slave modport; the driving environment uses master.
interface corner_packer_if;
    logic        corner;
    logic        corner_valid;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_x;
    logic [9:0]  out_y;
    logic        frame_done;
    logic [15:0] frame_corners;
    logic        overflow;

    modport master (
        output corner, corner_valid, out_ready,
        input  out_valid, out_x, out_y, frame_done, frame_corners, overflow
    );

    modport slave (
        input  corner, corner_valid, out_ready,
        output out_valid, out_x, out_y, frame_done, frame_corners, overflow
    );
endinterface

// File: rtl/corner_packer.sv
// Tracks raster position of a corner-decision stream, queues corner coordinates
// in a show-ahead FIFO and reports per-frame corner counts and sticky overflow.
module corner_packer #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    corner_packer_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [9:0]    X_LAST     = 10'(IMG_W - 1);
    localparam logic [9:0]    Y_LAST     = 10'(IMG_H - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } coord_t;

    logic [9:0]    x_q;
    logic [9:0]    y_q;
    coord_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [15:0]   frame_cnt_q;
    logic [15:0]   frame_corners_q;
    logic          frame_done_q;
    logic          overflow_q;

    logic          detect;
    logic          last_col;
    logic          last_pix;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [15:0]   frame_cnt_inc;
    coord_t        head;

    // NOTE: every signal in this block is assigned on every path, so no latch can form.
    always_comb begin
        detect        = bus.corner_valid && bus.corner;
        last_col      = (x_q == X_LAST);
        last_pix      = last_col && (y_q == Y_LAST);
        fifo_empty    = (count_q == '0);
        fifo_full     = (count_q == FULL_COUNT);
        pop           = !fifo_empty && bus.out_ready;
        push          = detect && (!fifo_full || pop);
        drop          = detect && fifo_full && !pop;
        frame_cnt_inc = (detect && (frame_cnt_q != 16'hFFFF)) ? frame_cnt_q + 16'd1
                                                              : frame_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q             <= '0;
            y_q             <= '0;
            frame_cnt_q     <= '0;
            frame_corners_q <= '0;
            frame_done_q    <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            frame_done_q <= bus.corner_valid && last_pix;
            overflow_q   <= overflow_q || drop;
            if (bus.corner_valid) begin
                if (last_col) begin
                    x_q <= '0;
                    y_q <= last_pix ? '0 : y_q + 10'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end
            // The last pixel's corner is folded into the published count.
            if (bus.corner_valid && last_pix) begin
                frame_corners_q <= frame_cnt_inc;
                frame_cnt_q     <= '0;
            end else begin
                frame_cnt_q     <= frame_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; out_valid and the output mux hide stale entries.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= '{x: x_q, y: y_q};
    end

    assign head              = mem[rd_ptr_q];
    assign bus.out_valid     = !fifo_empty;
    assign bus.out_x         = fifo_empty ? 10'd0 : head.x;
    assign bus.out_y         = fifo_empty ? 10'd0 : head.y;
    assign bus.frame_done    = frame_done_q;
    assign bus.frame_corners = frame_corners_q;
    assign bus.overflow      = overflow_q;

    assert property (@(posedge clk) disable iff (reset) count_q <= FULL_COUNT);
    assert property (@(posedge clk) disable iff (reset) frame_done_q |=> !frame_done_q);
endmodule

// File: tb/tb_corner_packer.sv
// Directed bench for corner_packer on a 4x4 frame with a 4-entry FIFO.
module tb_corner_packer;
    localparam int W = 4;
    localparam int H = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks  = 0;
    int   errors  = 0;
    int   fd_seen = 0;

    corner_packer_if bus ();

    corner_packer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic cv;
        logic c;
        logic rdy;
        logic ov;
        int   x;
        int   y;
        logic fd;
        int   fc;
        logic ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic cv, c, rdy, ov, input int x, y,
                                input logic fd, input int fc, input logic ovf);
        vec_t v;
        v.cv = cv; v.c = c; v.rdy = rdy; v.ov = ov; v.x = x; v.y = y;
        v.fd = fd; v.fc = fc; v.ovf = ovf;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic cv, input logic c, input logic rdy);
        bus.corner_valid = cv;
        bus.corner       = c;
        bus.out_ready    = rdy;
        @(posedge clk);
        #1;
        if (bus.frame_done === 1'b1) fd_seen++;
    endtask

    task automatic check_head(input string tag, input logic ov, input int x, input int y);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        check({tag, ".out_x"}, 32'(bus.out_x), x);
        check({tag, ".out_y"}, 32'(bus.out_y), y);
    endtask

    task automatic check_all(input string tag, input logic ov, input int x, input int y,
                             input logic fd, input int fc, input logic ovf);
        check_head(tag, ov, x, y);
        check({tag, ".frame_done"}, 32'(bus.frame_done), 32'(fd));
        check({tag, ".frame_corners"}, 32'(bus.frame_corners), fc);
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic is_c;

        // Single corner at pixel 5 = (1,1), consumer always ready.
        for (int p = 0; p < 5; p++) add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 1, 1, 0, 0, 0);
        for (int p = 6; p < 15; p++) add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0);

        reset = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        check_all("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].cv, vecs[i].c, vecs[i].rdy);
            check_all($sformatf("single[%0d]", i), vecs[i].ov, vecs[i].x, vecs[i].y,
                      vecs[i].fd, vecs[i].fc, vecs[i].ovf);
        end

        // Gapped frame: corners at pixels 0,5,10,15 with an idle cycle after every pixel.
        fd_seen = 0;
        for (int p = 0; p < W * H; p++) begin
            is_c = (p == 0) || (p == 5) || (p == 10) || (p == 15);
            step(1, is_c, 1);
            if (is_c) check_head($sformatf("gap_pix[%0d]", p), 1, p % W, p / W);
            else      check_head($sformatf("gap_pix[%0d]", p), 0, 0, 0);
            check($sformatf("gap_fd[%0d]", p), 32'(bus.frame_done), 32'(p == 15));
            step(0, 1, 1);
            check_head($sformatf("gap_idle[%0d]", p), 0, 0, 0);
        end
        check("gap.frame_done_pulses", fd_seen, 1);
        check("gap.frame_corners", 32'(bus.frame_corners), 4);

        // Backpressure: corners at (0,0),(2,0),(3,3) with out_ready low.
        for (int p = 0; p < W * H; p++) begin
            is_c = (p == 0) || (p == 2) || (p == 15);
            step(1, is_c, 0);
            check_head($sformatf("bp[%0d]", p), 1, 0, 0);
        end
        check("bp.frame_done", 32'(bus.frame_done), 1);
        check("bp.frame_corners", 32'(bus.frame_corners), 3);
        step(0, 0, 0);
        check_head("bp.hold0", 1, 0, 0);
        step(0, 0, 0);
        check_head("bp.hold1", 1, 0, 0);
        step(0, 0, 1);
        check_head("bp.pop1", 1, 2, 0);
        step(0, 0, 1);
        check_head("bp.pop2", 1, 3, 3);
        step(0, 0, 1);
        check_head("bp.pop3", 0, 0, 0);

        // Overflow: six corners into a 4-deep FIFO with out_ready low.
        for (int p = 0; p < W * H; p++) begin
            step(1, p < 6, 0);
            check_head($sformatf("ovf[%0d]", p), 1, 0, 0);
            check($sformatf("ovf.flag[%0d]", p), 32'(bus.overflow), 32'(p >= 4));
        end
        check("ovf.frame_done", 32'(bus.frame_done), 1);
        check("ovf.frame_corners", 32'(bus.frame_corners), 6);
        step(0, 0, 1);
        check_head("ovf.drain1", 1, 1, 0);
        step(0, 0, 1);
        check_head("ovf.drain2", 1, 2, 0);
        step(0, 0, 1);
        check_head("ovf.drain3", 1, 3, 0);
        step(0, 0, 1);
        check_head("ovf.drain4", 0, 0, 0);
        check("ovf.sticky", 32'(bus.overflow), 1);

        // Full FIFO with a corner arriving on a popping cycle.
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        check_all("fp.reset", 0, 0, 0, 0, 0, 0);
        for (int p = 0; p < 4; p++) step(1, 1, 0);
        check_head("fp.full", 1, 0, 0);
        step(1, 1, 1);
        check_head("fp.swap", 1, 1, 0);
        check("fp.overflow", 32'(bus.overflow), 0);
        step(0, 0, 1);
        check_head("fp.drain1", 1, 2, 0);
        step(0, 0, 1);
        check_head("fp.drain2", 1, 3, 0);
        step(0, 0, 1);
        check_head("fp.drain3", 1, 0, 1);
        step(0, 0, 1);
        check_head("fp.drain4", 0, 0, 0);
        check("fp.overflow_end", 32'(bus.overflow), 0);

        // Reset mid-frame with two queued corners; reset must beat a live corner.
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        for (int p = 0; p < 7; p++) step(1, (p == 1) || (p == 4), 0);
        check_head("mid.queued", 1, 1, 0);
        reset = 1'b1;
        step(1, 1, 0);
        reset = 1'b0;
        check_all("mid.reset", 0, 0, 0, 0, 0, 0);
        step(0, 0, 0);
        check_head("mid.idle", 0, 0, 0);
        step(1, 1, 0);
        check_head("mid.first", 1, 0, 0);
        step(1, 1, 1);
        check_head("mid.second", 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/corner_packer.md
CORNER_PACKER -- requirements
Module: corner_packer

Interface
REQ-001 SHALL have parameter IMG_W, default 64, pixels per row (2..1024).
REQ-002 SHALL have parameter IMG_H, default 64, rows per frame (2..1024).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, coordinate FIFO entries (power of 2, 2..256).
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port corner, input, 1, corner decision for the current pixel.
REQ-007 SHALL have port corner_valid, input, 1, qualifies corner; one pixel per asserted cycle, raster order.
REQ-008 SHALL have port out_valid, output, 1, FIFO head holds a coordinate.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the head entry.
REQ-010 SHALL have port out_x, output, 10, column of the head entry.
REQ-011 SHALL have port out_y, output, 10, row of the head entry.
REQ-012 SHALL have port frame_done, output, 1, single-cycle pulse at end of frame.
REQ-013 SHALL have port frame_corners, output, 16, corners detected in the last completed frame.
REQ-014 SHALL have port overflow, output, 1, sticky flag: a corner was dropped.

Function
REQ-015 SHALL keep column counter x and row counter y; each cycle with corner_valid=1 consumes pixel (x,y), then advances.
REQ-016 SHALL advance x by 1; when x=IMG_W-1, x wraps to 0 and y increments.
REQ-017 SHALL treat pixel (IMG_W-1,IMG_H-1) as last: x and y both wrap to 0 and frame_done pulses high for exactly the next cycle.
REQ-018 SHALL ignore corner and hold x and y when corner_valid=0; gaps of any length are legal.
REQ-019 SHALL push {x,y} into the FIFO on a cycle with corner_valid=1 and corner=1, unless the FIFO is full and not popping.
REQ-020 SHALL pop the head entry on a cycle with out_valid=1 and out_ready=1.
REQ-021 SHALL drive out_valid = FIFO not empty; out_x/out_y show the head entry (show-ahead). They hold their values while out_valid=1 and out_ready=0.
REQ-022 SHALL make a pushed entry visible on out_x/out_y with out_valid=1 on the cycle after the push when the FIFO was empty (latency 1).
REQ-023 SHALL accept a push when the FIFO is full if a pop occurs the same cycle; occupancy then stays at FIFO_DEPTH.
REQ-024 SHALL, on a simultaneous push and pop with the FIFO empty, perform only the push, because out_valid=0 prevents a pop.
REQ-025 SHALL drop a corner that arrives while the FIFO is full and not popping, and set overflow=1 from the next cycle until reset.
REQ-026 SHALL count every detected corner in a 16-bit frame counter, including dropped corners; the counter saturates at 65535.
REQ-027 SHALL load the frame counter value (including the last pixel's corner) into frame_corners on the frame_done cycle; the frame counter then restarts at 0.
REQ-028 SHALL leave FIFO contents intact across frame boundaries; entries from frame N may be read during frame N+1.
REQ-029 SHALL drive out_x/out_y as the low bits of x/y, zero-extended to 10 bits.

Reset
REQ-030 SHALL, on reset=1 at a clock edge: set x=0, y=0; empty the FIFO (out_valid=0); set frame_done=0, frame_corners=0, overflow=0; clear the frame counter.
REQ-031 SHALL give reset priority over all other inputs; a reset mid-frame discards partial-frame state, and the next valid pixel is (0,0).
REQ-032 SHALL drive out_x/out_y as 0 while the FIFO is empty after reset.

Verification
REQ-033 SHALL test single corner: IMG_W=IMG_H=4; corners at pixel 5 only; out_ready=1 -> one entry (1,1), out_valid high for 1 cycle; frame_done on the cycle after pixel 15; frame_corners=1.
REQ-034 SHALL test backpressure: out_ready=0; 3 corners at (0,0),(2,0),(3,3) -> out_valid holds (0,0) steadily; on release, entries pop in order, one per cycle.
REQ-035 SHALL test overflow: FIFO_DEPTH=4; out_ready=0; 6 corners -> 4 stored, overflow=1 after the 5th; frame_corners=6 at frame end.
REQ-036 SHALL test full with simultaneous pop: FIFO full, corner arrives while out_ready=1 -> no drop, overflow stays 0, occupancy stays 4.
REQ-037 SHALL test reset mid-frame: after 7 pixels and 2 queued corners, reset for 1 cycle -> out_valid=0; the next corner on the first valid pixel reads (0,0).
REQ-038 SHALL test gapped input: corner_valid toggling 1/0 over a full 4x4 frame -> coordinates identical to the gapless run; frame_done still pulses once.
